// File: rtl/prbs_chk_pkg.sv
// rtl/prbs_chk_pkg.sv - shared types and PRBS31 polynomial constants for the PRBS31 checker
package prbs_chk_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    // x^31 + x^28 + 1 with s[0] as the newest bit
    localparam int PRBS31_TAP_A = 30;
    localparam int PRBS31_TAP_B = 27;
    localparam int PRBS31_LEN   = 31;

endpackage

// File: rtl/prbs31_lock_checker_if.sv
// rtl/prbs31_lock_checker_if.sv - recovered bit stream into the PRBS31 lock checker
interface prbs31_lock_checker_if;

    logic data_in;
    logic data_in_valid;

    modport master (
        output data_in,
        output data_in_valid
    );

    modport slave (
        input data_in,
        input data_in_valid
    );

endinterface

// File: rtl/prbs31_predictor.sv
// rtl/prbs31_predictor.sv - PRBS31 history register and next-bit prediction, shared with the transmit generator
module prbs31_predictor
    import prbs_chk_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic shift_en,
    input  logic load_sel,
    input  logic bit_in,
    output logic p
);

    logic [PRBS31_LEN-1:0] s;

    assign p = s[PRBS31_TAP_A] ^ s[PRBS31_TAP_B];

    // load_sel = 1 free-runs on the prediction, 0 trains on the received bit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s <= '0;
        end else if (shift_en) begin
            s <= {s[PRBS31_LEN-2:0], (load_sel ? p : bit_in)};
        end
    end

endmodule

// File: rtl/prbs31_lock_checker.sv
// rtl/prbs31_lock_checker.sv - self-synchronising PRBS31 BER checker with lock/loss FSM (option: PRBS_CHK_WINDOW_BER_EN)
module prbs31_lock_checker
    import prbs_chk_pkg::*;
#(
    parameter int LOCK_THRESH = 64,
    parameter int LOSS_WINDOW = 256,
    parameter int ERR_THRESH  = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    prbs31_lock_checker_if.slave rx,
    output logic                 locked,
    output logic [CNT_WIDTH-1:0] total_bits,
    output logic [CNT_WIDTH-1:0] total_bit_errors,
    output logic [7:0]           lock_loss_count
`ifdef PRBS_CHK_WINDOW_BER_EN
    ,
    output logic [15:0]          win_errors
`endif
);

    localparam int WIN_W  = $clog2(LOSS_WINDOW);
    localparam int WERR_W = WIN_W + 1;

    chk_state_t        state;
    chk_state_t        state_nxt;
    logic [5:0]        fill_cnt;
    logic [7:0]        run_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [WERR_W-1:0] win_err;
    logic [WERR_W-1:0] win_err_inc;

    logic accept;
    logic p;
    logic mismatch;
    logic fill_full;
    logic run_hit;
    logic win_wrap;
    logic loss;

    assign accept      = en & rx.data_in_valid;
    assign mismatch    = rx.data_in ^ p;
    assign fill_full   = (fill_cnt == 6'(PRBS31_LEN));
    assign run_hit     = accept && (state == SEARCH) && fill_full && !mismatch
                         && (({1'b0, run_cnt} + 9'd1) == 9'(LOCK_THRESH));
    assign win_err_inc = win_err + WERR_W'(mismatch);
    assign win_wrap    = (win_cnt == WIN_W'(LOSS_WINDOW - 1));
    assign loss        = accept && (state == LOCKED) && mismatch
                         && (win_err_inc == WERR_W'(ERR_THRESH));
    assign locked      = (state == LOCKED);

    prbs31_predictor u_predictor (
        .clk      (clk),
        .rstn     (rstn),
        .shift_en (accept),
        .load_sel (state == LOCKED),
        .bit_in   (rx.data_in),
        .p        (p)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH: if (run_hit) state_nxt = LOCKED;
            LOCKED: if (loss)    state_nxt = SEARCH;
            default:             state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill_cnt         <= '0;
            run_cnt          <= '0;
            win_cnt          <= '0;
            win_err          <= '0;
            total_bits       <= '0;
            total_bit_errors <= '0;
            lock_loss_count  <= '0;
`ifdef PRBS_CHK_WINDOW_BER_EN
            win_errors       <= '0;
`endif
        end else if (accept) begin
            if (state == SEARCH) begin
                // no comparison until all 31 history bits come from the line
                if (!fill_full) begin
                    fill_cnt <= fill_cnt + 6'd1;
                end else if (mismatch || run_hit) begin
                    run_cnt <= '0;
                end else begin
                    run_cnt <= run_cnt + 8'd1;
                end
            end else begin
                if (~&total_bits) begin
                    total_bits <= total_bits + 1'b1;
                end
                if (mismatch && ~&total_bit_errors) begin
                    total_bit_errors <= total_bit_errors + 1'b1;
                end
                if (loss) begin
                    fill_cnt <= '0;
                    run_cnt  <= '0;
                    win_cnt  <= '0;
                    win_err  <= '0;
                    if (~&lock_loss_count) begin
                        lock_loss_count <= lock_loss_count + 8'd1;
                    end
                end else begin
                    // power-of-two window: the counter wraps on its own
                    win_cnt <= win_cnt + 1'b1;
                    win_err <= win_wrap ? '0 : win_err_inc;
                end
`ifdef PRBS_CHK_WINDOW_BER_EN
                if (win_wrap) begin
                    win_errors <= 16'(win_err_inc);
                end
`endif
            end
        end
    end

endmodule
